// File: rtl/axi_sram_slave.sv
// AXI responder backed by a word-addressed synchronous SRAM: single-beat strobed writes, INCR read bursts.
// Optional random back-pressure on all readies and R beats when AXI_SLAVE_STALL_EN is defined.
module axi_sram_slave #(
    parameter int          ADDR_WIDTH   = 14,
    parameter int          READ_LATENCY = 2,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESET,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [2:0]  S_AXI_AWSIZE,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [3:0]  S_AXI_ARID,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [3:0]  S_AXI_ARLEN,
    input  logic [2:0]  S_AXI_ARSIZE,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [3:0]  S_AXI_RID,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);
    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LAST = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;

    logic srst;
    logic stall;
    logic out_en_reg;
    assign srst = S_AXI_ARESET;

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWSIZE, S_AXI_ARSIZE,
                             S_AXI_AWADDR[31:ADDR_WIDTH+2], S_AXI_AWADDR[1:0],
                             S_AXI_ARADDR[31:ADDR_WIDTH+2], S_AXI_ARADDR[1:0]};

`ifdef AXI_SLAVE_STALL_EN
    logic [15:0] lfsr_reg;
    always_ff @(posedge S_AXI_ACLK) begin
        if (srst) lfsr_reg <= LFSR_SEED;
        else      lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end
    assign stall = lfsr_reg[0];
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign stall       = 1'b0;
`endif

    // Readies stay low until the first edge with reset released.
    always_ff @(posedge S_AXI_ACLK) begin
        out_en_reg <= !srst;
    end

    // ---------------- read path ----------------
    r_state_t              r_state_reg, r_state_next;
    logic [3:0]            rid_reg, rid_next;
    logic [ADDR_WIDTH-1:0] rd_idx_reg, rd_idx_next;
    logic [3:0]            cnt_reg, cnt_next;
    logic [3:0]            wait_reg, wait_next;
    logic                  rvalid_reg, rvalid_next;
    logic                  rd_load;
    logic                  ar_hs;

    assign S_AXI_ARREADY = out_en_reg && (r_state_reg == R_IDLE) && !stall;
    assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;

    always_comb begin
        r_state_next = r_state_reg;
        rid_next     = rid_reg;
        rd_idx_next  = rd_idx_reg;
        cnt_next     = cnt_reg;
        wait_next    = wait_reg;
        rvalid_next  = rvalid_reg;
        rd_load      = 1'b0;
        case (r_state_reg)
            R_IDLE: if (ar_hs) begin
                rid_next    = S_AXI_ARID;
                rd_idx_next = S_AXI_ARADDR[ADDR_WIDTH+1:2];
                cnt_next    = S_AXI_ARLEN;
                wait_next   = 4'd0;
                if (READ_LATENCY == 1) begin
                    r_state_next = R_DATA;
                    rd_load      = !stall;
                    rvalid_next  = !stall;
                end else begin
                    r_state_next = R_WAIT;
                end
            end
            R_WAIT: if (wait_reg == WAIT_LAST) begin
                r_state_next = R_DATA;
                rd_load      = !stall;
                rvalid_next  = !stall;
            end else begin
                wait_next = wait_reg + 4'd1;
            end
            R_DATA: if (rvalid_reg) begin
                if (S_AXI_RREADY) begin
                    if (cnt_reg == 4'd0) begin
                        r_state_next = R_IDLE;
                        rvalid_next  = 1'b0;
                    end else begin
                        rd_idx_next = rd_idx_reg + ADDR_WIDTH'(1);
                        cnt_next    = cnt_reg - 4'd1;
                        rd_load     = !stall;
                        rvalid_next = !stall;
                    end
                end
            end else if (!stall) begin
                // beat deferred by a stall: raise it now at the already-advanced index
                rd_load     = 1'b1;
                rvalid_next = 1'b1;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (srst) begin
            r_state_reg <= R_IDLE;
            rid_reg     <= '0;
            rd_idx_reg  <= '0;
            cnt_reg     <= '0;
            wait_reg    <= '0;
            rvalid_reg  <= 1'b0;
        end else begin
            r_state_reg <= r_state_next;
            rid_reg     <= rid_next;
            rd_idx_reg  <= rd_idx_next;
            cnt_reg     <= cnt_next;
            wait_reg    <= wait_next;
            rvalid_reg  <= rvalid_next;
        end
    end

    assign S_AXI_RVALID = rvalid_reg;
    assign S_AXI_RLAST  = rvalid_reg && (cnt_reg == 4'd0);
    assign S_AXI_RID    = rid_reg;
    assign S_AXI_RRESP  = 2'b00;

    // ---------------- write path ----------------
    w_state_t              w_state_reg, w_state_next;
    logic [ADDR_WIDTH-1:0] w_idx_reg, w_idx_next;
    logic [31:0]           w_data_reg, w_data_next;
    logic [3:0]            w_strb_reg, w_strb_next;
    logic                  wr_en, wr_commit;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic                  aw_hs, w_hs;

    assign S_AXI_AWREADY = out_en_reg && ((w_state_reg == W_IDLE) || (w_state_reg == W_HAVE_D)) && !stall;
    assign S_AXI_WREADY  = out_en_reg && ((w_state_reg == W_IDLE) || (w_state_reg == W_HAVE_A)) && !stall;
    assign aw_hs         = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs          = S_AXI_WVALID && S_AXI_WREADY;

    always_comb begin
        w_state_next = w_state_reg;
        w_idx_next   = w_idx_reg;
        w_data_next  = w_data_reg;
        w_strb_next  = w_strb_reg;
        wr_en        = 1'b0;
        wr_idx       = w_idx_reg;
        wr_data      = w_data_reg;
        wr_strb      = w_strb_reg;
        case (w_state_reg)
            W_IDLE: if (aw_hs && w_hs) begin
                wr_en        = 1'b1;
                wr_idx       = S_AXI_AWADDR[ADDR_WIDTH+1:2];
                wr_data      = S_AXI_WDATA;
                wr_strb      = S_AXI_WSTRB;
                w_state_next = W_RESP;
            end else if (aw_hs) begin
                w_idx_next   = S_AXI_AWADDR[ADDR_WIDTH+1:2];
                w_state_next = W_HAVE_A;
            end else if (w_hs) begin
                w_data_next  = S_AXI_WDATA;
                w_strb_next  = S_AXI_WSTRB;
                w_state_next = W_HAVE_D;
            end
            W_HAVE_A: if (w_hs) begin
                wr_en        = 1'b1;
                wr_data      = S_AXI_WDATA;
                wr_strb      = S_AXI_WSTRB;
                w_state_next = W_RESP;
            end
            W_HAVE_D: if (aw_hs) begin
                wr_en        = 1'b1;
                wr_idx       = S_AXI_AWADDR[ADDR_WIDTH+1:2];
                w_state_next = W_RESP;
            end
            W_RESP: if (S_AXI_BREADY) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (srst) begin
            w_state_reg <= W_IDLE;
            w_idx_reg   <= '0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
        end else begin
            w_state_reg <= w_state_next;
            w_idx_reg   <= w_idx_next;
            w_data_reg  <= w_data_next;
            w_strb_reg  <= w_strb_next;
        end
    end

    assign wr_commit    = wr_en && !srst;
    assign S_AXI_BVALID = (w_state_reg == W_RESP);
    assign S_AXI_BRESP  = 2'b00;

    // One byte-wide read-first RAM per lane; a same-edge write is not visible to the beat read on that edge.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] q_reg;
            always_ff @(posedge S_AXI_ACLK) begin
                if (wr_commit && wr_strb[gi]) mem[wr_idx] <= wr_data[gi*8 +: 8];
            end
            always_ff @(posedge S_AXI_ACLK) begin
                if (srst)         q_reg <= '0;
                else if (rd_load) q_reg <= mem[rd_idx_next];
            end
            assign S_AXI_RDATA[gi*8 +: 8] = q_reg;
        end
    endgenerate
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave; the stall scenario runs when AXI_SLAVE_STALL_EN is defined.
module tb_axi_sram_slave;
    logic        clk = 1'b0;
    logic        S_AXI_ARESET;
    logic [31:0] S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWSIZE;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARID;
    logic [31:0] S_AXI_ARADDR;
    logic [3:0]  S_AXI_ARLEN;
    logic [2:0]  S_AXI_ARSIZE;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [3:0]  S_AXI_RID;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    always #5 clk = ~clk;

    axi_sram_slave dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(S_AXI_ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWSIZE(S_AXI_AWSIZE),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    int tests = 0;
    int fails = 0;
    int aw_stalls = 0, w_stalls = 0, ar_stalls = 0, r_gaps = 0, vdrop = 0;
    logic [31:0] rd_buf [16];
    int          rd_last_at, rd_nbeats;
    logic [3:0]  rd_id;

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_done = 0, w_done = 0;
        int n = 0;
        @(posedge clk); #1;
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1; S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1;
        S_AXI_BREADY = 1;
        while (!(aw_done && w_done) && n < 200) begin
            @(negedge clk);
            if (S_AXI_AWVALID) begin if (S_AXI_AWREADY) aw_done = 1; else aw_stalls++; end
            if (S_AXI_WVALID)  begin if (S_AXI_WREADY)  w_done  = 1; else w_stalls++;  end
            @(posedge clk); #1;
            if (aw_done) S_AXI_AWVALID = 0;
            if (w_done)  S_AXI_WVALID  = 0;
            n++;
        end
        n = 0;
        while (n < 200) begin
            @(negedge clk); n++;
            if (S_AXI_BVALID) break;
        end
        @(posedge clk); #1;
        tests++;
        if (!(aw_done && w_done) || n >= 200) begin
            fails++;
            $display("FAIL write_timeout: addr %h aw_done %0d w_done %0d, required completion", a, aw_done, w_done);
        end
        $display("[TB] WR addr=%h data=%h strb=%h", a, d, s);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] len, input logic [3:0] id, input bit toggle);
        int n = 0;
        bit done = 0, held = 0;
        logic [31:0] hd = '0;
        logic hl = 1'b0;
        rd_last_at = -1; rd_nbeats = 0; rd_id = '0;
        @(posedge clk); #1;
        S_AXI_ARADDR = a; S_AXI_ARLEN = len; S_AXI_ARID = id; S_AXI_ARVALID = 1;
        S_AXI_RREADY = !toggle;
        while (n < 300) begin
            @(negedge clk); n++;
            if (S_AXI_ARREADY) break;
            ar_stalls++;
        end
        @(posedge clk); #1;
        S_AXI_ARVALID = 0;
        if (n >= 300) begin
            tests++; fails++;
            $display("FAIL ar_timeout: ARREADY never seen for addr %h", a);
            return;
        end
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk); n++;
            if (S_AXI_RVALID) begin
                if (held && (S_AXI_RDATA !== hd || S_AXI_RLAST !== hl)) vdrop++;
                if (S_AXI_RREADY) begin
                    if (rd_nbeats < 16) rd_buf[rd_nbeats] = S_AXI_RDATA;
                    rd_id = S_AXI_RID;
                    if (S_AXI_RLAST) begin rd_last_at = rd_nbeats; done = 1; end
                    rd_nbeats++;
                    held = 0;
                end else begin
                    held = 1; hd = S_AXI_RDATA; hl = S_AXI_RLAST;
                end
            end else begin
                if (held) vdrop++;
                if (rd_nbeats > 0) r_gaps++;
                held = 0;
            end
            @(posedge clk); #1;
            if (toggle) S_AXI_RREADY = !S_AXI_RREADY;
        end
        S_AXI_RREADY = 1;
        if (!done) begin
            tests++; fails++;
            $display("FAIL r_timeout: burst at %h got %0d beats without RLAST", a, rd_nbeats);
        end
        $display("[TB] RD addr=%h len=%0d id=%0d beats=%0d first=%h", a, len, id, rd_nbeats, rd_buf[0]);
    endtask

    task automatic test_reset();
        S_AXI_ARESET = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if ({S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b000) begin
            fails++; $display("FAIL reset_readies: got %b, expected 000", {S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_WREADY}); end
        tests++; if ({S_AXI_RVALID, S_AXI_BVALID, S_AXI_RLAST} !== 3'b000) begin
            fails++; $display("FAIL reset_valids: got %b, expected 000", {S_AXI_RVALID, S_AXI_BVALID, S_AXI_RLAST}); end
        tests++; if (S_AXI_RDATA !== 32'h0 || S_AXI_RID !== 4'h0) begin
            fails++; $display("FAIL reset_rdata_rid: got %h/%h, expected 0/0", S_AXI_RDATA, S_AXI_RID); end
        @(posedge clk); #1;
        S_AXI_ARESET = 0;
        @(posedge clk);
        @(negedge clk);
`ifndef AXI_SLAVE_STALL_EN
        tests++; if ({S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b111) begin
            fails++; $display("FAIL post_reset_readies: got %b, expected 111", {S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_WREADY}); end
`endif
        $display("[TB] reset sequence done");
    endtask

    task automatic test_single_write_read();
        @(posedge clk); #1;
        S_AXI_AWADDR = 32'h10; S_AXI_AWVALID = 1; S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF;
        S_AXI_WVALID = 1; S_AXI_BREADY = 0;
        @(negedge clk);
        tests++; if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b11) begin
            fails++; $display("FAIL same_cycle_ready: got %b, expected 11", {S_AXI_AWREADY, S_AXI_WREADY}); end
        @(posedge clk); #1;
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        @(negedge clk);
        tests++; if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00 || S_AXI_AWREADY !== 1'b0) begin
            fails++; $display("FAIL bvalid_next: got bvalid %b bresp %b awready %b, expected 1 00 0", S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY); end
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if (S_AXI_BVALID !== 1'b1) begin
            fails++; $display("FAIL bvalid_held: got %b, expected 1", S_AXI_BVALID); end
        @(posedge clk); #1;
        S_AXI_BREADY = 1;
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1) begin
            fails++; $display("FAIL after_b: got bvalid %b awready %b, expected 0 1", S_AXI_BVALID, S_AXI_AWREADY); end
        @(posedge clk); #1;
        S_AXI_ARADDR = 32'h10; S_AXI_ARLEN = 0; S_AXI_ARID = 4'h5; S_AXI_ARVALID = 1; S_AXI_RREADY = 1;
        @(negedge clk);
        tests++; if (S_AXI_ARREADY !== 1'b1) begin
            fails++; $display("FAIL arready_idle: got %b, expected 1", S_AXI_ARREADY); end
        @(posedge clk); #1;
        S_AXI_ARVALID = 0;
        @(negedge clk);
        tests++; if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b0) begin
            fails++; $display("FAIL latency_early: got rvalid %b arready %b, expected 0 0", S_AXI_RVALID, S_AXI_ARREADY); end
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'hDEADBEEF || S_AXI_RLAST !== 1'b1 || S_AXI_RID !== 4'h5) begin
            fails++; $display("FAIL single_beat: got v%b d%h l%b id%h, expected v1 dDEADBEEF l1 id5", S_AXI_RVALID, S_AXI_RDATA, S_AXI_RLAST, S_AXI_RID); end
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
            fails++; $display("FAIL after_last: got rvalid %b arready %b, expected 0 1", S_AXI_RVALID, S_AXI_ARREADY); end
        $display("[TB] single write/read at 0x10 done");
    endtask

    task automatic test_w_before_aw();
        do_write(32'h20, 32'hFFFFFFFF, 4'hF);
        @(posedge clk); #1;
        S_AXI_WDATA = 32'h11223344; S_AXI_WSTRB = 4'b0101; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
        @(negedge clk);
        tests++; if (S_AXI_WREADY !== 1'b1) begin
            fails++; $display("FAIL w_first_ready: got %b, expected 1", S_AXI_WREADY); end
        @(posedge clk); #1;
        S_AXI_WVALID = 0;
        @(negedge clk);
        tests++; if ({S_AXI_WREADY, S_AXI_AWREADY, S_AXI_BVALID} !== 3'b010) begin
            fails++; $display("FAIL have_d_flags: got %b, expected 010", {S_AXI_WREADY, S_AXI_AWREADY, S_AXI_BVALID}); end
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if (S_AXI_BVALID !== 1'b0) begin
            fails++; $display("FAIL no_early_b: got %b, expected 0", S_AXI_BVALID); end
        @(posedge clk); #1;
        S_AXI_AWADDR = 32'h20; S_AXI_AWVALID = 1;
        @(negedge clk);
        tests++; if (S_AXI_AWREADY !== 1'b1) begin
            fails++; $display("FAIL aw_late_ready: got %b, expected 1", S_AXI_AWREADY); end
        @(posedge clk); #1;
        S_AXI_AWVALID = 0;
        @(negedge clk);
        tests++; if (S_AXI_BVALID !== 1'b1) begin
            fails++; $display("FAIL late_commit_b: got %b, expected 1", S_AXI_BVALID); end
        @(posedge clk); #1;
        do_read(32'h20, 4'd0, 4'd0, 1'b0);
        tests++; if (rd_buf[0] !== 32'hFF22FF44) begin
            fails++; $display("FAIL strobe_merge: got %h, expected FF22FF44", rd_buf[0]); end
    endtask

    task automatic test_burst_toggle();
        for (int i = 0; i < 16; i++) do_write(32'(i * 4), 32'h1000_0000 + 32'(i), 4'hF);
        r_gaps = 0; vdrop = 0;
        do_read(32'h0, 4'd15, 4'h3, 1'b1);
        tests++; if (rd_nbeats !== 16 || rd_last_at !== 15) begin
            fails++; $display("FAIL burst_count: got %0d beats rlast at %0d, expected 16 / 15", rd_nbeats, rd_last_at); end
        tests++; if (rd_id !== 4'h3) begin
            fails++; $display("FAIL burst_rid: got %h, expected 3", rd_id); end
        tests++; if (vdrop !== 0) begin
            fails++; $display("FAIL burst_stable: got %0d unstable stalls, expected 0", vdrop); end
        tests++; if (r_gaps !== 0) begin
            fails++; $display("FAIL burst_bubbles: got %0d bubbles, expected 0", r_gaps); end
        for (int i = 0; i < 16; i++) begin
            tests++; if (rd_buf[i] !== 32'h1000_0000 + 32'(i)) begin
                fails++; $display("FAIL burst_data[%0d]: got %h, expected %h", i, rd_buf[i], 32'h1000_0000 + 32'(i)); end
        end
    endtask

    task automatic test_wrap();
        do_write(32'h0000_FFF8, 32'hA0A0_0001, 4'hF);
        do_write(32'h0000_FFFC, 32'hA0A0_0002, 4'hF);
        do_write(32'h0001_0000, 32'hA0A0_0003, 4'hF);
        do_write(32'h0000_0004, 32'hA0A0_0004, 4'hF);
        do_read(32'h0000_FFF8, 4'd3, 4'h1, 1'b0);
        tests++; if (rd_last_at !== 3) begin
            fails++; $display("FAIL wrap_rlast: got %0d, expected 3", rd_last_at); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (rd_buf[i] !== 32'hA0A0_0001 + 32'(i)) begin
                fails++; $display("FAIL wrap_data[%0d]: got %h, expected %h", i, rd_buf[i], 32'hA0A0_0001 + 32'(i)); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int n = 0, beats = 0, stray = 0;
        @(posedge clk); #1;
        S_AXI_ARADDR = 32'h0; S_AXI_ARLEN = 4'd7; S_AXI_ARID = 4'h6; S_AXI_ARVALID = 1; S_AXI_RREADY = 1;
        @(negedge clk);
        @(posedge clk); #1;
        S_AXI_ARVALID = 0;
        while (n < 50) begin
            @(negedge clk); n++;
            if (S_AXI_RVALID) begin
                if (beats == 2) break;
                beats++;
            end
        end
        tests++; if (n >= 50) begin
            fails++; $display("FAIL midburst_timeout: got %0d beats, expected third beat", beats); end
        S_AXI_ARESET = 1;
        @(negedge clk);
        tests++; if ({S_AXI_RVALID, S_AXI_ARREADY, S_AXI_AWREADY} !== 3'b000) begin
            fails++; $display("FAIL midburst_reset: got %b, expected 000", {S_AXI_RVALID, S_AXI_ARREADY, S_AXI_AWREADY}); end
        @(posedge clk); #1;
        S_AXI_ARESET = 0;
        repeat (6) begin
            @(negedge clk);
            if (S_AXI_RVALID) stray++;
        end
        tests++; if (stray !== 0) begin
            fails++; $display("FAIL stray_beats: got %0d, expected 0", stray); end
        do_read(32'h10, 4'd0, 4'h2, 1'b0);
        tests++; if (rd_buf[0] !== 32'h1000_0004 || rd_nbeats !== 1 || rd_id !== 4'h2) begin
            fails++; $display("FAIL fresh_ar: got %h beats %0d id %h, expected 10000004 1 2", rd_buf[0], rd_nbeats, rd_id); end
    endtask

    task automatic test_reset_pending_write();
        @(posedge clk); #1;
        S_AXI_AWADDR = 32'h30; S_AXI_AWVALID = 1; S_AXI_WVALID = 0;
        @(negedge clk);
        tests++; if (S_AXI_AWREADY !== 1'b1) begin
            fails++; $display("FAIL pend_aw_ready: got %b, expected 1", S_AXI_AWREADY); end
        @(posedge clk); #1;
        S_AXI_AWVALID = 0; S_AXI_ARESET = 1;
        S_AXI_WDATA = 32'h5555_5555; S_AXI_WSTRB = 4'hF;
        @(posedge clk); #1;
        S_AXI_ARESET = 0;
        do_read(32'h30, 4'd0, 4'h0, 1'b0);
        tests++; if (rd_buf[0] !== 32'h1000_000C) begin
            fails++; $display("FAIL pending_discard: got %h, expected 1000000C", rd_buf[0]); end
    endtask

`ifdef AXI_SLAVE_STALL_EN
    task automatic test_stall();
        logic [31:0] model [200];
        aw_stalls = 0; w_stalls = 0; ar_stalls = 0; r_gaps = 0; vdrop = 0;
        for (int i = 0; i < 200; i++) begin
            model[i] = $urandom;
            do_write(32'h400 + 32'(i * 4), model[i], 4'hF);
        end
        for (int b = 0; b < 13; b++) begin
            do_read(32'h400 + 32'(b * 64), 4'd15, 4'(b), 1'(b % 2));
            tests++; if (rd_nbeats !== 16) begin
                fails++; $display("FAIL stall_beats[%0d]: got %0d, expected 16", b, rd_nbeats); end
            for (int j = 0; j < 16; j++) begin
                if (b * 16 + j < 200) begin
                    tests++; if (rd_buf[j] !== model[b * 16 + j]) begin
                        fails++; $display("FAIL stall_data[%0d]: got %h, expected %h", b * 16 + j, rd_buf[j], model[b * 16 + j]); end
                end
            end
        end
        tests++; if (vdrop !== 0) begin
            fails++; $display("FAIL stall_valid_drop: got %0d, expected 0", vdrop); end
        tests++; if (aw_stalls == 0 || w_stalls == 0 || ar_stalls == 0 || r_gaps == 0) begin
            fails++; $display("FAIL stall_seen: got aw %0d w %0d ar %0d r %0d, expected all nonzero", aw_stalls, w_stalls, ar_stalls, r_gaps); end
    endtask
`endif

    initial begin
        S_AXI_ARESET = 1; S_AXI_AWADDR = '0; S_AXI_AWSIZE = 3'd2; S_AXI_AWVALID = 0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
        S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = 3'd2;
        S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
        test_reset();
`ifdef AXI_SLAVE_STALL_EN
        test_stall();
`else
        test_single_write_read();
        test_w_before_aw();
        test_burst_toggle();
        test_wrap();
        test_reset_mid_burst();
        test_reset_pending_write();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
